cfu_vec_mac: RTL and testbench
==============================

CFU_VEC_MAC -- requirements
Module: cfu_vec_mac

Interface
REQ-001 SHALL have parameter INPUT_OFFSET, default 128, signed offset added to each sign-extended matrix byte before multiply.
REQ-002 SHALL have parameter LEN_W, default 16, width of the word-count register.
REQ-003 SHALL have parameter ADDR_W, default 30, width of the word address on the memory bus.
REQ-004 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: cmd_valid  in  1; cmd_ready  out  1; cmd_payload_function_id  in  10  opcode in [2:0]; cmd_payload_inputs_0  in  32; cmd_payload_inputs_1  in  32.
REQ-006 SHALL have ports: rsp_valid  out  1; rsp_ready  in  1; rsp_payload_outputs_0  out  32.
REQ-007 SHALL have Wishbone master ports: cfu_ram_adr  out  ADDR_W; cfu_ram_dat_mosi  out  32; cfu_ram_sel  out  4; cfu_ram_cyc  out  1; cfu_ram_stb  out  1; cfu_ram_we  out  1; cfu_ram_cti  out  3; cfu_ram_bte  out  2; cfu_ram_dat_miso  in  32; cfu_ram_ack  in  1; cfu_ram_err  in  1.

Function
REQ-008 SHALL tie cfu_ram_sel=4'hF, we=0, cti=0, bte=0, dat_mosi=0 (read-only classic Wishbone).
REQ-009 SHALL assert cmd_ready only in IDLE; a command is accepted on a cycle with cmd_valid && cmd_ready.
REQ-010 SHALL decode opcode [2:0]: 0 SET_LEN (len<=inputs_0[LEN_W-1:0], rsp=0); 1 RUN; 2 CLEAR (rsp=old acc, acc<=0, status<=0); 3 READ_ACC (rsp=acc); 4 STATUS (rsp={30'b0, err_flag, busy=0}); 5-7 rsp=0; bits [9:3] ignored.
REQ-011 SHALL respond to non-RUN opcodes with rsp_valid asserted the cycle after acceptance.
REQ-012 SHALL implement states IDLE, FETCH_A, FETCH_B, MAC, RESP.
REQ-013 RUN SHALL latch a_ptr<=inputs_0[31:2], b_ptr<=inputs_1[31:2], remaining<=len; if len==0 go to RESP directly, else FETCH_A.
REQ-014 FETCH_A SHALL drive adr=a_ptr, cyc=stb=1; on ack capture miso into a_word and go to FETCH_B.
REQ-015 FETCH_B SHALL drive adr=b_ptr, cyc=stb=1; on ack capture miso into b_word and go to MAC.
REQ-016 cyc/stb SHALL deassert in the cycle following each ack (one classic transaction per word, no back-to-back stb).
REQ-017 MAC SHALL compute acc<=acc+sum over lanes i=0..3 of (sext(a_word[8i+7:8i])+INPUT_OFFSET)*sext(b_word[8i+7:8i]), wrapping modulo 2^32; increment a_ptr,b_ptr by 1 (wrap at 2^ADDR_W); decrement remaining; go to FETCH_A if remaining>1 else RESP.
REQ-018 Each lane product SHALL be computed at >=17 bits signed; sum at 32 bits signed.
REQ-019 err during FETCH_A/FETCH_B SHALL abort: drop cyc/stb, set sticky err_flag, leave acc at its pre-fault value of the current word, go to RESP with rsp=32'h8000_0000.
REQ-020 RESP SHALL present rsp_valid=1 with rsp_payload=acc (or error code) and hold both stable until rsp_ready; on rsp_valid&&rsp_ready return to IDLE.
REQ-021 acc SHALL persist across RUN commands until CLEAR or reset.
REQ-022 ack and err asserted together SHALL be treated as err.
REQ-023 ack/err received outside FETCH states SHALL be ignored.

Reset
REQ-024 reset SHALL asynchronously force state=IDLE, acc=0, len=0, err_flag=0, rsp_valid=0, rsp_payload=0, cyc=stb=0, adr=0.
REQ-025 reset asserted mid-transaction SHALL drop cyc/stb immediately; no response is issued for the aborted command.

Verification
REQ-026 SET_LEN 1; RUN with mem[A]=32'h00000000, mem[B]=32'h01010101 -> rsp=4*128*1=512, exactly 2 bus transactions.
REQ-027 SET_LEN 3, words A={0x7F7F7F7F x3}, B={0xFFFFFFFF x3} -> each lane (127+128)*(-1)=-255, rsp=-3060 (0xFFFFF40C); READ_ACC returns same.
REQ-028 SET_LEN 0; RUN -> no cyc asserted, rsp=current acc one cycle later.
REQ-029 SET_LEN 2, slave asserts err on second FETCH_A -> rsp=0x80000000; STATUS=2; CLEAR returns first-word result and STATUS then 0.
REQ-030 RUN with rsp_ready held low 5 cycles -> rsp_valid and payload stable, cmd_ready low throughout; slave ack delayed 0 and 3 cycles gives identical results.
REQ-031 reset pulsed while FETCH_B stb high -> cyc/stb low same cycle, cmd_ready high after release, READ_ACC=0.

Source files
------------

// File: rtl/cfu_vec_mac.sv
// Vector multiply-accumulate CFU: streams int8 word pairs over a read-only
// classic Wishbone master and accumulates offset-adjusted 4-lane dot products.
module cfu_vec_mac #(
  parameter int INPUT_OFFSET = 128,
  parameter int LEN_W        = 16,
  parameter int ADDR_W       = 30
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [9:0]        cmd_payload_function_id,
  input  logic [31:0]       cmd_payload_inputs_0,
  input  logic [31:0]       cmd_payload_inputs_1,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_payload_outputs_0,

  output logic [ADDR_W-1:0] cfu_ram_adr,
  output logic [31:0]       cfu_ram_dat_mosi,
  output logic [3:0]        cfu_ram_sel,
  output logic              cfu_ram_cyc,
  output logic              cfu_ram_stb,
  output logic              cfu_ram_we,
  output logic [2:0]        cfu_ram_cti,
  output logic [1:0]        cfu_ram_bte,
  input  logic [31:0]       cfu_ram_dat_miso,
  input  logic              cfu_ram_ack,
  input  logic              cfu_ram_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH_A = 3'd1,
    FETCH_B = 3'd2,
    MAC     = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [2:0] OP_SET_LEN  = 3'd0;
  localparam logic [2:0] OP_RUN      = 3'd1;
  localparam logic [2:0] OP_CLEAR    = 3'd2;
  localparam logic [2:0] OP_READ_ACC = 3'd3;
  localparam logic [2:0] OP_STATUS   = 3'd4;

  localparam logic [31:0] ERR_CODE = 32'h8000_0000;

  state_t            state;
  state_t            state_next;
  logic [31:0]       acc;
  logic [31:0]       rsp_data;
  logic [31:0]       a_word;
  logic [31:0]       b_word;
  logic [31:0]       dot_sum;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  remaining;
  logic [ADDR_W-1:0] a_ptr;
  logic [ADDR_W-1:0] b_ptr;
  logic [ADDR_W-1:0] bus_adr;
  logic              err_flag;
  logic              bus_active;
  logic [2:0]        opcode;
  logic              cmd_fire;
  logic              rsp_fire;
  logic              bus_ack;
  logic              bus_err;
  logic              unused_inputs;

  logic signed [31:0] lane_a;
  logic signed [31:0] lane_b;
  logic signed [31:0] lane_p;

  assign opcode   = cmd_payload_function_id[2:0];
  assign cmd_fire = cmd_valid && (state == IDLE);
  assign rsp_fire = (state == RESP) && rsp_ready;

  // Bus handshakes only count while our own strobe is out; err wins over ack.
  assign bus_err = bus_active && cfu_ram_err;
  assign bus_ack = bus_active && cfu_ram_ack && !cfu_ram_err;

  assign unused_inputs = ^{cmd_payload_function_id[9:3],
                           cmd_payload_inputs_0[1:0],
                           cmd_payload_inputs_1[1:0]};

  assign cfu_ram_dat_mosi = '0;
  assign cfu_ram_sel      = 4'hF;
  assign cfu_ram_we       = 1'b0;
  assign cfu_ram_cti      = 3'd0;
  assign cfu_ram_bte      = 2'd0;

  always_comb begin
    dot_sum = '0;
    lane_a  = '0;
    lane_b  = '0;
    lane_p  = '0;
    for (int i = 0; i < 4; i++) begin
      lane_a  = 32'($signed(a_word[8*i +: 8])) + 32'(INPUT_OFFSET);
      lane_b  = 32'($signed(b_word[8*i +: 8]));
      lane_p  = lane_a * lane_b;
      dot_sum = dot_sum + lane_p;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (cmd_fire) begin
          if (opcode == OP_RUN) begin
            state_next = (len == '0) ? RESP : FETCH_A;
          end else begin
            state_next = RESP;
          end
        end
      end
      FETCH_A: begin
        if (bus_err) begin
          state_next = RESP;
        end else if (bus_ack) begin
          state_next = FETCH_B;
        end
      end
      FETCH_B: begin
        if (bus_err) begin
          state_next = RESP;
        end else if (bus_ack) begin
          state_next = MAC;
        end
      end
      MAC: begin
        state_next = (remaining > LEN_W'(1)) ? FETCH_A : RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready             = (state == IDLE);
    rsp_valid             = (state == RESP);
    rsp_payload_outputs_0 = rsp_data;
    cfu_ram_cyc           = bus_active;
    cfu_ram_stb           = bus_active;
    cfu_ram_adr           = bus_adr;
  end

  // Each fetch state spends one cycle with the strobe low before raising it,
  // which guarantees a bubble between consecutive classic transactions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      len        <= '0;
      err_flag   <= 1'b0;
      rsp_data   <= '0;
      bus_active <= 1'b0;
      bus_adr    <= '0;
      a_ptr      <= '0;
      b_ptr      <= '0;
      remaining  <= '0;
      a_word     <= '0;
      b_word     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_fire) begin
            unique case (opcode)
              OP_SET_LEN: begin
                len      <= cmd_payload_inputs_0[LEN_W-1:0];
                rsp_data <= '0;
              end
              OP_RUN: begin
                a_ptr     <= ADDR_W'(cmd_payload_inputs_0[31:2]);
                b_ptr     <= ADDR_W'(cmd_payload_inputs_1[31:2]);
                remaining <= len;
                rsp_data  <= acc;
              end
              OP_CLEAR: begin
                rsp_data <= acc;
                acc      <= '0;
                err_flag <= 1'b0;
              end
              OP_READ_ACC: rsp_data <= acc;
              OP_STATUS:   rsp_data <= {30'b0, err_flag, 1'b0};
              default:     rsp_data <= '0;
            endcase
          end
        end
        FETCH_A: begin
          if (!bus_active) begin
            bus_active <= 1'b1;
            bus_adr    <= a_ptr;
          end else if (bus_err) begin
            bus_active <= 1'b0;
            err_flag   <= 1'b1;
            rsp_data   <= ERR_CODE;
          end else if (bus_ack) begin
            bus_active <= 1'b0;
            a_word     <= cfu_ram_dat_miso;
          end
        end
        FETCH_B: begin
          if (!bus_active) begin
            bus_active <= 1'b1;
            bus_adr    <= b_ptr;
          end else if (bus_err) begin
            bus_active <= 1'b0;
            err_flag   <= 1'b1;
            rsp_data   <= ERR_CODE;
          end else if (bus_ack) begin
            bus_active <= 1'b0;
            b_word     <= cfu_ram_dat_miso;
          end
        end
        MAC: begin
          acc       <= acc + dot_sum;
          rsp_data  <= acc + dot_sum;
          a_ptr     <= a_ptr + 1'b1;
          b_ptr     <= b_ptr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        RESP: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cfu_vec_mac.sv
// Self-checking bench for cfu_vec_mac: a Wishbone memory slave with
// configurable ack delay and error injection, plus a dot-product reference model.
module tb_cfu_vec_mac;

  localparam int ADDR_W = 30;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [9:0]        cmd_payload_function_id;
  logic [31:0]       cmd_payload_inputs_0;
  logic [31:0]       cmd_payload_inputs_1;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_payload_outputs_0;
  logic [ADDR_W-1:0] cfu_ram_adr;
  logic [31:0]       cfu_ram_dat_mosi;
  logic [3:0]        cfu_ram_sel;
  logic              cfu_ram_cyc;
  logic              cfu_ram_stb;
  logic              cfu_ram_we;
  logic [2:0]        cfu_ram_cti;
  logic [1:0]        cfu_ram_bte;
  logic [31:0]       cfu_ram_dat_miso;
  logic              cfu_ram_ack;
  logic              cfu_ram_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [256];
  int          ack_delay = 0;
  int          err_at = -1;
  int          txn_count = 0;
  int          wait_cnt = 0;
  bit          cyc_seen = 0;
  bit          responded = 0;
  int          bubble_violations = 0;
  logic [31:0] model_acc = '0;

  cfu_vec_mac #(.INPUT_OFFSET(128), .LEN_W(16), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0),
    .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .cfu_ram_adr(cfu_ram_adr),
    .cfu_ram_dat_mosi(cfu_ram_dat_mosi),
    .cfu_ram_sel(cfu_ram_sel),
    .cfu_ram_cyc(cfu_ram_cyc),
    .cfu_ram_stb(cfu_ram_stb),
    .cfu_ram_we(cfu_ram_we),
    .cfu_ram_cti(cfu_ram_cti),
    .cfu_ram_bte(cfu_ram_bte),
    .cfu_ram_dat_miso(cfu_ram_dat_miso),
    .cfu_ram_ack(cfu_ram_ack),
    .cfu_ram_err(cfu_ram_err)
  );

  always #5 clk = ~clk;

  // Memory slave, evaluated just after each rising edge.
  initial begin
    cfu_ram_ack      = 1'b0;
    cfu_ram_err      = 1'b0;
    cfu_ram_dat_miso = '0;
    forever begin
      @(posedge clk);
      #1;
      if (responded && cfu_ram_cyc) bubble_violations++;
      responded = 0;
      if (cfu_ram_cyc && cfu_ram_stb) begin
        cyc_seen = 1;
        if (cfu_ram_ack || cfu_ram_err) begin
          cfu_ram_ack = 1'b0;
          cfu_ram_err = 1'b0;
        end else if (wait_cnt < ack_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt  = 0;
          responded = 1;
          if (txn_count == err_at) begin
            cfu_ram_err = 1'b1;
          end else begin
            cfu_ram_ack      = 1'b1;
            cfu_ram_dat_miso = mem[cfu_ram_adr[7:0]];
          end
          txn_count++;
        end
      end else begin
        cfu_ram_ack = 1'b0;
        cfu_ram_err = 1'b0;
        wait_cnt    = 0;
      end
    end
  end

  function automatic logic [31:0] dot(input logic [31:0] a, input logic [31:0] b);
    int  s;
    byte av;
    byte bv;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      av = a[8*i +: 8];
      bv = b[8*i +: 8];
      s  = s + (int'(av) + 128) * int'(bv);
    end
    return 32'(s);
  endfunction

  function automatic logic [31:0] model_run(input logic [31:0] start, input int n,
                                            input logic [29:0] ap, input logic [29:0] bp);
    logic [31:0] s;
    logic [7:0]  ia;
    logic [7:0]  ib;
    s = start;
    for (int k = 0; k < n; k++) begin
      ia = ap[7:0] + 8'(k);
      ib = bp[7:0] + 8'(k);
      s  = s + dot(mem[ia], mem[ib]);
    end
    return s;
  endfunction

  task automatic issue_cmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1);
    int n;
    @(negedge clk);
    cmd_payload_function_id = fid;
    cmd_payload_inputs_0    = in0;
    cmd_payload_inputs_1    = in1;
    cmd_valid               = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL cmd_accept: cmd_ready=%b required 1 within 100 cycles", cmd_ready);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [31:0] rsp, output int lat);
    int n;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rsp_timeout: rsp_valid=%b required 1 within 2000 cycles", rsp_valid);
    end
    rsp = rsp_payload_outputs_0;
    lat = n;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
  endtask

  task automatic send_cmd(input logic [9:0] fid, input logic [31:0] in0, input logic [31:0] in1,
                          output logic [31:0] rsp, output int lat);
    issue_cmd(fid, in0, in1);
    wait_rsp(rsp, lat);
    release_rsp();
  endtask

  task automatic test_reset();
    logic [31:0] r;
    int          lat;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cfu_ram_cyc !== 1'b0 || cfu_ram_stb !== 1'b0 || cfu_ram_adr !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bus: cyc=%b stb=%b adr=%h required 0 0 0", cfu_ram_cyc, cfu_ram_stb, cfu_ram_adr);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_payload_outputs_0 !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rsp: valid=%b payload=%h required 0 00000000", rsp_valid, rsp_payload_outputs_0);
    end
    checks++;
    if (cfu_ram_sel !== 4'hF || cfu_ram_we !== 1'b0 || cfu_ram_cti !== 3'd0 ||
        cfu_ram_bte !== 2'd0 || cfu_ram_dat_mosi !== 32'h0) begin
      errors++;
      $display("[TB] FAIL bus_ties: sel=%h we=%b cti=%h bte=%h mosi=%h required f 0 0 0 0",
               cfu_ram_sel, cfu_ram_we, cfu_ram_cti, cfu_ram_bte, cfu_ram_dat_mosi);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_cmd_ready: got %b required 1", cmd_ready);
    end
    send_cmd(10'd3, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_acc: got %h required 00000000", r);
    end
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("[TB] FAIL rsp_latency: got %0d cycles required 0", lat);
    end
    send_cmd(10'd4, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_status: got %h required 00000000", r);
    end
  endtask

  task automatic test_single_word();
    logic [31:0] r;
    int          lat;
    int          t0;
    mem[16] = 32'h0000_0000;
    mem[32] = 32'h0101_0101;
    send_cmd(10'd0, 32'd1, 32'h0, r, lat);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL set_len_rsp: got %h required 00000000", r);
    end
    t0 = txn_count;
    send_cmd(10'd1, 32'h0000_0041, 32'h0000_0082, r, lat);
    model_acc = model_run(model_acc, 1, 30'd16, 30'd32);
    checks++;
    if (r !== 32'd512) begin
      errors++;
      $display("[TB] FAIL single_word: got %h required 00000200", r);
    end
    checks++;
    if (txn_count - t0 !== 2) begin
      errors++;
      $display("[TB] FAIL single_word_txns: got %0d required 2", txn_count - t0);
    end
  endtask

  task automatic test_multi_word();
    logic [31:0] r;
    int          lat;
    send_cmd(10'd2, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== model_acc) begin
      errors++;
      $display("[TB] FAIL clear_old_acc: got %h required %h", r, model_acc);
    end
    model_acc = '0;
    for (int i = 0; i < 3; i++) begin
      mem[40+i] = 32'h7F7F_7F7F;
      mem[48+i] = 32'hFFFF_FFFF;
    end
    send_cmd(10'd0, 32'd3, 32'h0, r, lat);
    send_cmd(10'd1, 32'd40 << 2, 32'd48 << 2, r, lat);
    model_acc = model_run(model_acc, 3, 30'd40, 30'd48);
    checks++;
    if (r !== 32'hFFFF_F40C) begin
      errors++;
      $display("[TB] FAIL multi_word: got %h required fffff40c", r);
    end
    send_cmd(10'd3, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== model_acc) begin
      errors++;
      $display("[TB] FAIL multi_word_read_acc: got %h required %h", r, model_acc);
    end
  endtask

  task automatic test_len_zero();
    logic [31:0] r;
    int          lat;
    int          t0;
    send_cmd(10'd0, 32'd0, 32'h0, r, lat);
    cyc_seen = 0;
    t0 = txn_count;
    send_cmd(10'd1, 32'h100, 32'h200, r, lat);
    checks++;
    if (r !== model_acc) begin
      errors++;
      $display("[TB] FAIL len_zero_rsp: got %h required %h", r, model_acc);
    end
    checks++;
    if (lat !== 0) begin
      errors++;
      $display("[TB] FAIL len_zero_latency: got %0d required 0", lat);
    end
    checks++;
    if (cyc_seen !== 1'b0 || txn_count !== t0) begin
      errors++;
      $display("[TB] FAIL len_zero_bus: cyc_seen=%b txns=%0d required 0 0", cyc_seen, txn_count - t0);
    end
  endtask

  task automatic test_error();
    logic [31:0] r;
    logic [31:0] first;
    int          lat;
    int          t0;
    send_cmd(10'd2, 32'h0, 32'h0, r, lat);
    model_acc = '0;
    mem[64] = $urandom;
    mem[65] = $urandom;
    mem[80] = $urandom;
    mem[81] = $urandom;
    send_cmd(10'd0, 32'd2, 32'h0, r, lat);
    t0     = txn_count;
    err_at = txn_count + 2;
    send_cmd(10'd1, 32'd64 << 2, 32'd80 << 2, r, lat);
    err_at = -1;
    first  = model_run(32'h0, 1, 30'd64, 30'd80);
    checks++;
    if (r !== 32'h8000_0000) begin
      errors++;
      $display("[TB] FAIL err_rsp: got %h required 80000000", r);
    end
    checks++;
    if (txn_count - t0 !== 3) begin
      errors++;
      $display("[TB] FAIL err_txns: got %0d required 3", txn_count - t0);
    end
    send_cmd(10'd4, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'd2) begin
      errors++;
      $display("[TB] FAIL err_status: got %h required 00000002", r);
    end
    send_cmd(10'd2, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== first) begin
      errors++;
      $display("[TB] FAIL err_clear_acc: got %h required %h", r, first);
    end
    send_cmd(10'd4, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'd0) begin
      errors++;
      $display("[TB] FAIL status_after_clear: got %h required 00000000", r);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [31:0] held;
    logic [31:0] results [2];
    logic [31:0] expect_val;
    int          lat;
    for (int i = 0; i < 2; i++) begin
      mem[100+i] = $urandom;
      mem[110+i] = $urandom;
    end
    expect_val = model_run(32'h0, 2, 30'd100, 30'd110);
    for (int pass = 0; pass < 2; pass++) begin
      ack_delay = (pass == 0) ? 0 : 3;
      send_cmd(10'd2, 32'h0, 32'h0, r, lat);
      send_cmd(10'd0, 32'd2, 32'h0, r, lat);
      issue_cmd(10'd1, 32'd100 << 2, 32'd110 << 2);
      wait_rsp(held, lat);
      for (int c = 0; c < 5; c++) begin
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_payload_outputs_0 !== held || cmd_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL backpressure_hold: valid=%b payload=%h cmd_ready=%b required 1 %h 0",
                   rsp_valid, rsp_payload_outputs_0, cmd_ready, held);
        end
      end
      release_rsp();
      results[pass] = held;
      checks++;
      if (held !== expect_val) begin
        errors++;
        $display("[TB] FAIL ack_delay_%0d_result: got %h required %h", ack_delay, held, expect_val);
      end
    end
    ack_delay = 0;
    checks++;
    if (results[1] !== results[0]) begin
      errors++;
      $display("[TB] FAIL ack_delay_equal: delay3=%h required %h", results[1], results[0]);
    end
    model_acc = expect_val;
  endtask

  task automatic test_random();
    logic [31:0] r;
    logic [29:0] ap;
    logic [29:0] bp;
    int          lat;
    int          n;
    int          t0;
    send_cmd(10'd2, 32'h0, 32'h0, r, lat);
    model_acc = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int it = 0; it < 10; it++) begin
      n  = $urandom_range(1, 6);
      ap = (it == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      bp = 30'($urandom);
      ack_delay = $urandom_range(0, 2);
      send_cmd({7'($urandom), 3'd0}, 32'(n), 32'h0, r, lat);
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("[TB] FAIL rand_set_len: got %h required 00000000", r);
      end
      t0 = txn_count;
      send_cmd({7'($urandom), 3'd1}, {ap, 2'($urandom)}, {bp, 2'($urandom)}, r, lat);
      model_acc = model_run(model_acc, n, ap, bp);
      checks++;
      if (r !== model_acc) begin
        errors++;
        $display("[TB] FAIL rand_run_%0d: got %h required %h (len %0d)", it, r, model_acc, n);
      end
      checks++;
      if (txn_count - t0 !== 2 * n) begin
        errors++;
        $display("[TB] FAIL rand_txns_%0d: got %0d required %0d", it, txn_count - t0, 2 * n);
      end
    end
    ack_delay = 0;
  endtask

  task automatic test_opcodes();
    logic [31:0] r;
    int          lat;
    for (int op = 5; op < 8; op++) begin
      send_cmd({7'($urandom), 3'(op)}, $urandom, $urandom, r, lat);
      checks++;
      if (r !== 32'h0) begin
        errors++;
        $display("[TB] FAIL opcode_%0d: got %h required 00000000", op, r);
      end
    end
    send_cmd({7'h55, 3'd3}, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== model_acc) begin
      errors++;
      $display("[TB] FAIL read_acc_high_bits: got %h required %h", r, model_acc);
    end
    @(negedge clk);
    cfu_ram_ack = 1'b1;
    cfu_ram_err = 1'b1;
    @(posedge clk);
    #1;
    cfu_ram_ack = 1'b0;
    cfu_ram_err = 1'b0;
    send_cmd(10'd4, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL stray_err_status: got %h required 00000000", r);
    end
    send_cmd(10'd3, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== model_acc) begin
      errors++;
      $display("[TB] FAIL stray_ack_acc: got %h required %h", r, model_acc);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    int          lat;
    int          n;
    int          t0;
    bit          saw_rsp;
    send_cmd(10'd0, 32'd4, 32'h0, r, lat);
    ack_delay = 4;
    t0 = txn_count;
    issue_cmd(10'd1, 32'd8 << 2, 32'd12 << 2);
    n = 0;
    while (!(txn_count > t0 && cfu_ram_stb === 1'b1) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!(txn_count > t0 && cfu_ram_stb === 1'b1)) begin
      errors++;
      $display("[TB] FAIL fetch_b_reach: stb=%b txns=%0d required 1 and >=1", cfu_ram_stb, txn_count - t0);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (cfu_ram_cyc !== 1'b0 || cfu_ram_stb !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_drop_bus: cyc=%b stb=%b required 0 0", cfu_ram_cyc, cfu_ram_stb);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset     = 1'b0;
    ack_delay = 0;
    model_acc = '0;
    saw_rsp   = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) saw_rsp = 1;
    end
    checks++;
    if (cmd_ready !== 1'b1 || saw_rsp) begin
      errors++;
      $display("[TB] FAIL post_reset_idle: cmd_ready=%b stray_rsp=%b required 1 0", cmd_ready, saw_rsp);
    end
    send_cmd(10'd3, 32'h0, 32'h0, r, lat);
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("[TB] FAIL post_reset_acc: got %h required 00000000", r);
    end
    cyc_seen = 0;
    send_cmd(10'd1, 32'h40, 32'h80, r, lat);
    checks++;
    if (r !== 32'h0 || cyc_seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_len: rsp=%h cyc_seen=%b required 00000000 0", r, cyc_seen);
    end
  endtask

  initial begin
    reset                   = 1'b1;
    cmd_valid               = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
    rsp_ready               = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;

    $display("[TB] starting cfu_vec_mac bench");
    test_reset();
    test_single_word();
    test_multi_word();
    test_len_zero();
    test_error();
    test_back_to_back();
    test_random();
    test_opcodes();
    test_reset_mid();

    checks++;
    if (bubble_violations !== 0) begin
      errors++;
      $display("[TB] FAIL stb_bubble: got %0d back-to-back strobes required 0", bubble_violations);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
